// File: rtl/sync_up_counter_pkg.sv
// Shared counter constants: default geometry and the value an out-of-range load clamps to.
// Down-counter variants import the same package so load clamping stays consistent.
package sync_up_counter_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_MODULUS    = 16;
    localparam int LOAD_CLAMP_VAL = 0;

    // A full-range modulus wraps by plain binary rollover, so no clear is needed.
    function automatic bit is_pow2_modulus(input int width, input int modulus);
        return modulus == (1 << width);
    endfunction

endpackage

// File: rtl/sync_up_counter_if.sv
// Control and status bundle of one counter: the driver (master) owns en/load/clr_ovf,
// the counter (slave) returns count, combinational carry-out and the sticky wrap flag.
interface sync_up_counter_if
    import sync_up_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             co;
    logic             ovf;

    modport master (
        output en, load, load_val, clr_ovf,
        input  count, co, ovf
    );

    modport slave (
        input  en, load, load_val, clr_ovf,
        output count, co, ovf
    );

endinterface

// File: rtl/sync_up_counter_count_stage.sv
// One counter bit: synchronous reset, then parallel load, then toggle, else hold.
// Latency 1 cycle; no backpressure, the stage acts on every rising edge.
module count_stage (
    input  logic clk,
    input  logic rst,
    input  logic toggle,
    input  logic load,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (toggle) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync_up_counter.sv
// Modulo-MODULUS synchronous up-counter with load, enable, sticky wrap flag and cascade carry.
// Latency 1 cycle from load/en to count; co is combinational; no backpressure.
module sync_up_counter
    import sync_up_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic              clk,
    input  logic              rst,
    sync_up_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] CLAMP_VAL = WIDTH'(LOAD_CLAMP_VAL);
    localparam bit               NEED_CLR  = !is_pow2_modulus(WIDTH, MODULUS);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] load_dat;
    logic             at_max;
    logic             wrap;
    logic             sync_clr;
    logic             stage_load;
    logic             val_fits;
    logic             ovf_q;
    logic             ovf_d;

    assign at_max     = (count == MAX_VAL);
    assign wrap       = bus.en & at_max & ~bus.load;
    // A short modulus wraps by loading zero into every stage on the terminal count.
    assign sync_clr   = NEED_CLR & wrap;
    assign stage_load = bus.load | sync_clr;
    assign val_fits   = ({1'b0, bus.load_val} < (WIDTH + 1)'(MODULUS));
    assign load_dat   = !bus.load ? '0 : (val_fits ? bus.load_val : CLAMP_VAL);

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_lsb
            assign carry[i] = bus.en;
        end else begin : g_upper
            assign carry[i] = carry[i-1] & count[i-1];
        end

        count_stage u_stage (
            .clk    (clk),
            .rst    (rst),
            .toggle (carry[i]),
            .load   (stage_load),
            .d      (load_dat[i]),
            .q      (count[i])
        );
    end

    // A wrap on the same edge as clr_ovf keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.count = count;
    assign bus.co    = bus.en & at_max;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter: modulus-16 and modulus-10 counters side by side plus a two-digit
// decimal cascade, checked every cycle against an arithmetic model of the counting rules.
module tb_sync_up_counter;

    logic clk;
    logic rst;
    logic casc_en;

    sync_up_counter_if #(.WIDTH(4)) bus16 ();
    sync_up_counter_if #(.WIDTH(4)) bus10 ();
    sync_up_counter_if #(.WIDTH(4)) bus_lo ();
    sync_up_counter_if #(.WIDTH(4)) bus_hi ();

    sync_up_counter #(.WIDTH(4), .MODULUS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
    sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));
    sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));

    assign bus_lo.en = casc_en;
    assign bus_hi.en = bus_lo.co;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mod_of [2] = '{16, 10};
    int m_cnt  [2] = '{0, 0};
    int m_ovf  [2] = '{0, 0};
    int m_casc = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, check combinational carry-outs, clock, then check registers.
    task automatic cycle(input bit r, input bit e, input bit l, input int lv, input bit c, input bit ce);
        int nxt;
        bit wrapped;
        rst            = r;
        bus16.en       = e;
        bus16.load     = l;
        bus16.load_val = 4'(lv);
        bus16.clr_ovf  = c;
        bus10.en       = e;
        bus10.load     = l;
        bus10.load_val = 4'(lv);
        bus10.clr_ovf  = c;
        casc_en        = ce;
        #1;
        check_eq("co16",   32'(bus16.co),  32'(e && m_cnt[0] == 15));
        check_eq("co10",   32'(bus10.co),  32'(e && m_cnt[1] == 9));
        check_eq("co_lo",  32'(bus_lo.co), 32'(ce && (m_casc % 10) == 9));
        check_eq("co_hi",  32'(bus_hi.co), 32'(ce && m_casc == 99));
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            wrapped = 1'b0;
            if (r) begin
                m_cnt[k] = 0;
                m_ovf[k] = 0;
            end else begin
                if (l) begin
                    m_cnt[k] = (lv < mod_of[k]) ? lv : 0;
                end else if (e) begin
                    nxt      = m_cnt[k] + 1;
                    wrapped  = (nxt == mod_of[k]);
                    m_cnt[k] = nxt % mod_of[k];
                end
                if (wrapped) m_ovf[k] = 1;
                else if (c)  m_ovf[k] = 0;
            end
        end
        if (r)       m_casc = 0;
        else if (ce) m_casc = (m_casc + 1) % 100;
        check_eq("cnt16",  32'(bus16.count),  32'(m_cnt[0]));
        check_eq("ovf16",  32'(bus16.ovf),    32'(m_ovf[0]));
        check_eq("cnt10",  32'(bus10.count),  32'(m_cnt[1]));
        check_eq("ovf10",  32'(bus10.ovf),    32'(m_ovf[1]));
        check_eq("cnt_lo", 32'(bus_lo.count), 32'(m_casc % 10));
        check_eq("cnt_hi", 32'(bus_hi.count), 32'(m_casc / 10));
    endtask

    initial begin
        rst             = 1'b1;
        casc_en         = 1'b0;
        bus_lo.load     = 1'b0;
        bus_lo.load_val = '0;
        bus_lo.clr_ovf  = 1'b0;
        bus_hi.load     = 1'b0;
        bus_hi.load_val = '0;
        bus_hi.clr_ovf  = 1'b0;

        // Reset, then a long enabled run through wraps of both moduli.
        repeat (2) cycle(1, 0, 0, 0, 0, 0);
        check_eq("reset_cnt16", 32'(bus16.count), 0);
        check_eq("reset_ovf16", 32'(bus16.ovf), 0);
        check_eq("reset_cnt10", 32'(bus10.count), 0);
        repeat (20) cycle(0, 1, 0, 0, 0, 0);
        check_eq("run20_cnt16", 32'(bus16.count), 4);
        check_eq("run20_ovf16", 32'(bus16.ovf), 1);
        check_eq("run20_cnt10", 32'(bus10.count), 0);
        check_eq("run20_ovf10", 32'(bus10.ovf), 1);

        // Load takes priority over en, then counting resumes.
        cycle(0, 1, 1, 5, 0, 0);
        check_eq("load5_cnt16", 32'(bus16.count), 5);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);
        check_eq("load5_resume10", 32'(bus10.count), 7);

        // Out-of-range load clamps to zero; the terminal value loads as-is.
        cycle(0, 0, 1, 12, 0, 0);
        check_eq("load12_cnt10", 32'(bus10.count), 0);
        check_eq("load12_cnt16", 32'(bus16.count), 12);
        cycle(0, 0, 1, 9, 0, 0);
        check_eq("load9_cnt10", 32'(bus10.count), 9);
        cycle(0, 1, 0, 0, 0, 0);
        check_eq("load9_wrap10", 32'(bus10.count), 0);

        // Hold with en low.
        cycle(0, 0, 1, 7, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        check_eq("hold7_cnt16", 32'(bus16.count), 7);

        // Reset beats a simultaneous load and clr_ovf.
        cycle(1, 1, 1, 3, 1, 0);
        check_eq("rst_load_cnt10", 32'(bus10.count), 0);
        check_eq("rst_load_ovf10", 32'(bus10.ovf), 0);

        // Reset in the middle of counting.
        cycle(0, 0, 1, 11, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check_eq("rst_mid_cnt16", 32'(bus16.count), 0);

        // Wrap and clr_ovf on the same edge: the wrap wins; a lone clear then drops the flag.
        cycle(0, 0, 1, 9, 0, 0);
        cycle(0, 1, 0, 0, 1, 0);
        check_eq("collide_ovf10", 32'(bus10.ovf), 1);
        cycle(0, 0, 0, 0, 1, 0);
        check_eq("clear_ovf10", 32'(bus10.ovf), 0);

        // Random traffic on all controls.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(99) < 3),
                  ($urandom_range(99) < 75),
                  ($urandom_range(99) < 10),
                  int'($urandom_range(15)),
                  ($urandom_range(99) < 10),
                  ($urandom_range(99) < 70));
        end

        // Decimal cascade: 25 enabled cycles from reset read 2:5.
        cycle(1, 0, 0, 0, 0, 0);
        repeat (25) cycle(0, 0, 0, 0, 0, 1);
        check_eq("cascade_hi", 32'(bus_hi.count), 2);
        check_eq("cascade_lo", 32'(bus_lo.count), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
